align_shift_unit: RTL and testbench

ALIGN_SHIFT_UNIT -- requirements
Module: align_shift_unit

---
 rtl/align_shift_unit_if.sv | 42 ++++
 rtl/align_shift_unit.sv | 138 +++++++++++++
 tb/tb_align_shift_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/align_shift_unit_if.sv
// -----------------------------------------------------------------------------
// align_shift_unit_if
// Operand/result handshake bundle for align_shift_unit.
//
// Signals (names are from the unit's point of view):
//   i_valid   - operand valid (producer -> unit)
//   o_ready   - unit can accept an operand
//   i_man     - SIZE_MAN-bit mantissa to align, hidden bit included
//   i_shamt   - SIZE_SHIFT-bit unsigned right-shift distance
//   o_valid   - aligned result valid
//   i_ready   - downstream accepts the result
//   o_man_ext - SIZE_MAN_EXT-bit aligned mantissa {man, guard, round, ext, sticky}
//   o_busy    - unit is not idle
//
// Modports:
//   slave  - the alignment unit
//   master - the surrounding environment (operand source and result sink)
// -----------------------------------------------------------------------------
interface align_shift_unit_if #(
  parameter int SIZE_MAN     = 24,
  parameter int SIZE_MAN_EXT = 28,
  parameter int SIZE_SHIFT   = 8
);
  logic                    i_valid;
  logic                    o_ready;
  logic [SIZE_MAN-1:0]     i_man;
  logic [SIZE_SHIFT-1:0]   i_shamt;
  logic                    o_valid;
  logic                    i_ready;
  logic [SIZE_MAN_EXT-1:0] o_man_ext;
  logic                    o_busy;

  modport slave (
    input  i_valid, i_man, i_shamt, i_ready,
    output o_ready, o_valid, o_man_ext, o_busy
  );

  modport master (
    output i_valid, i_man, i_shamt, i_ready,
    input  o_ready, o_valid, o_man_ext, o_busy
  );
endinterface

// File: rtl/align_shift_unit.sv
// -----------------------------------------------------------------------------
// align_shift_unit
// Iterative mantissa alignment: right-shifts an extended mantissa by an
// exponent difference, at most STEP bit positions per clock, folding every
// bit shifted out into a sticky bit (bit 0 of the result).
//
// Ports:
//   i_clk   - clock, rising edge active
//   i_rst_n - asynchronous active-low reset
//   bus     - align_shift_unit_if.slave: operand valid/ready handshake
//             (i_valid, o_ready, i_man, i_shamt), result valid/ready
//             handshake (o_valid, i_ready, o_man_ext) and o_busy status
//
// Result layout o_man_ext: [SIZE_MAN_EXT-1:4] shifted mantissa, [3] guard,
// [2] round, [1] extension, [0] sticky.
//
// Configuration macro:
//   ALIGN_EARLY_SAT_EN - when defined, a shift distance >= SIZE_MAN_EXT is
//   resolved on the accept edge (result = sticky only) instead of iterating.
//   The result value is identical either way; only latency changes.
// -----------------------------------------------------------------------------
module align_shift_unit #(
  parameter int SIZE_MAN     = 24,
  parameter int SIZE_MAN_EXT = 28,
  parameter int SIZE_SHIFT   = 8,
  parameter int STEP         = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  align_shift_unit_if.slave bus
);

  localparam int                    EXT_PAD = SIZE_MAN_EXT - SIZE_MAN;
  localparam logic [SIZE_SHIFT-1:0] STEP_W  = SIZE_SHIFT'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [SIZE_MAN_EXT-1:0] work_q;
  logic [SIZE_SHIFT-1:0]   cnt_q;
  logic [SIZE_SHIFT-1:0]   step_amt;
  logic [SIZE_SHIFT-1:0]   cnt_rem;
  logic                    accept;
`ifdef ALIGN_EARLY_SAT_EN
  logic                    sat_shift;
`endif

  // Right shift by s (s <= STEP) where the new bit 0 is the OR of every old
  // bit in [s:0]: bits leaving the word, plus the old sticky, all collapse
  // into the sticky position so it can never be lost.
  function automatic logic [SIZE_MAN_EXT-1:0] sticky_shr(
    input logic [SIZE_MAN_EXT-1:0] v,
    input logic [SIZE_SHIFT-1:0]   s
  );
    logic [SIZE_MAN_EXT-1:0] r;
    logic                    st;
    st = 1'b0;
    for (int i = 0; i <= STEP; i++) begin
      if (SIZE_SHIFT'(i) <= s) st = st | v[i];
    end
    r    = v >> s;
    r[0] = st;
    return r;
  endfunction

  assign accept   = (state_q == IDLE) && bus.i_valid;
  assign step_amt = (cnt_q < STEP_W) ? cnt_q : STEP_W;
  assign cnt_rem  = cnt_q - step_amt;
`ifdef ALIGN_EARLY_SAT_EN
  assign sat_shift = (32'(bus.i_shamt) >= SIZE_MAN_EXT);
`endif

  // ---- control: state register --------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
`ifdef ALIGN_EARLY_SAT_EN
          if (sat_shift)                 state_d = DONE;
          else if (bus.i_shamt != '0)    state_d = SHIFT;
          else                           state_d = DONE;
`else
          if (bus.i_shamt != '0)         state_d = SHIFT;
          else                           state_d = DONE;
`endif
        end
      end
      SHIFT:   if (cnt_rem == '0) state_d = DONE;
      DONE:    if (bus.i_ready)   state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state_q == IDLE);
    bus.o_valid = (state_q == DONE);
    bus.o_busy  = (state_q != IDLE);
  end

  // ---- datapath: work register and remaining-shift counter ----------------
  // Reset clears the data too so o_man_ext reads zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
`ifdef ALIGN_EARLY_SAT_EN
      if (sat_shift) begin
        work_q <= {{(SIZE_MAN_EXT-1){1'b0}}, |bus.i_man};
        cnt_q  <= '0;
      end else begin
        work_q <= {bus.i_man, {EXT_PAD{1'b0}}};
        cnt_q  <= bus.i_shamt;
      end
`else
      work_q <= {bus.i_man, {EXT_PAD{1'b0}}};
      cnt_q  <= bus.i_shamt;
`endif
    end else if (state_q == SHIFT) begin
      work_q <= sticky_shr(work_q, step_amt);
      cnt_q  <= cnt_rem;
    end
  end

  assign bus.o_man_ext = work_q;

endmodule

// File: tb/tb_align_shift_unit.sv
module tb_align_shift_unit;

  logic clk;
  logic rst_n;

  align_shift_unit_if #(.SIZE_MAN(24), .SIZE_MAN_EXT(28), .SIZE_SHIFT(8)) bus ();

  align_shift_unit #(
    .SIZE_MAN(24), .SIZE_MAN_EXT(28), .SIZE_SHIFT(8), .STEP(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] man;
    logic [7:0]  sh;
    logic [27:0] exp_man;
  } vec_t;

  typedef struct {
    logic [27:0] man;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: one-shot shift of the extended mantissa, with every bit that
  // falls off the end ORed into bit 0.
  function automatic logic [27:0] ref_align(input logic [23:0] man, input int sh);
    logic [63:0] full;
    logic [63:0] r;
    logic        st;
    full = {36'b0, man, 4'b0};
    if (sh >= 28) return {27'b0, |man};
    r  = full >> sh;
    st = |(full & ((64'd1 << sh) - 64'd1));
    return r[27:0] | {27'b0, st};
  endfunction

  function automatic int exp_lat(input int sh);
`ifdef ALIGN_EARLY_SAT_EN
    if (sh >= 28) return 1;
`endif
    return 1 + (sh + 3) / 4;
  endfunction

  // Drive one operand, push its expectation, wait for the result, compare,
  // optionally hold the result for 'hold' cycles, then drain it.
  // 'inject' presents a second operand on the edge after acceptance.
  task automatic do_op(input logic [23:0] man, input logic [7:0] sh,
                       input logic [27:0] exp_man, input int lat,
                       input int hold, input bit inject, input string nm);
    exp_t e;
    int   edges;
    int   extra;
    @(negedge clk);
    check({nm, "_ready_in"}, bus.o_ready, 1);
    bus.i_valid = 1'b1;
    bus.i_man   = man;
    bus.i_shamt = sh;
    e.man = exp_man;
    e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    if (inject) begin
      bus.i_man   = 24'hFFFFFF;
      bus.i_shamt = 8'd0;
    end else begin
      bus.i_valid = 1'b0;
    end
    edges = 1;
    while (!bus.o_valid && edges < 200) begin
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      edges++;
    end
    bus.i_valid = 1'b0;
    check({nm, "_valid"}, bus.o_valid, 1);
    if (sb.size() == 0) begin
      check({nm, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({nm, "_man"}, bus.o_man_ext, e.man);
      check({nm, "_latency"}, edges, e.lat);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({nm, "_hold_valid"}, bus.o_valid, 1);
      check({nm, "_hold_man"}, bus.o_man_ext, e.man);
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    check({nm, "_ready_out"}, bus.o_ready, 1);
    check({nm, "_valid_drop"}, bus.o_valid, 0);
    if (inject) begin
      extra = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (bus.o_valid) extra++;
      end
      check({nm, "_no_second"}, extra, 0);
    end
  endtask

  vec_t tbl[9];

  initial begin
    int          nval;
    logic [23:0] rm;
    logic [7:0]  rs;

    tbl[0] = '{24'hC00001, 8'd0,   28'hC000010};
    tbl[1] = '{24'hC00001, 8'd5,   28'h0600001};
    tbl[2] = '{24'h800000, 8'd30,  28'h0000001};
    tbl[3] = '{24'h000000, 8'd13,  28'h0000000};
    tbl[4] = '{24'hFFFFFF, 8'd4,   28'h0FFFFFF};
    tbl[5] = '{24'h800000, 8'd27,  28'h0000001};
    tbl[6] = '{24'h800001, 8'd8,   28'h0080001};
    tbl[7] = '{24'hABCDEF, 8'd1,   28'h55E6F78};
    tbl[8] = '{24'h800000, 8'd255, 28'h0000001};

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_man   = '0;
    bus.i_shamt = '0;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.o_ready, 1);
    check("rst_valid", bus.o_valid, 0);
    check("rst_busy",  bus.o_busy,  0);
    check("rst_man",   bus.o_man_ext, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_op(tbl[i].man, tbl[i].sh, tbl[i].exp_man, exp_lat(int'(tbl[i].sh)), 0, 1'b0,
            $sformatf("vec%0d", i));

    // Result held in DONE while downstream stalls.
    do_op(24'hC00001, 8'd5, 28'h0600001, 3, 5, 1'b0, "hold");

    // Second operand offered while shifting must be dropped.
    do_op(24'hC00001, 8'd8, 28'h00C0001, 3, 0, 1'b1, "inject");

    // Reset in the middle of a long shift.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_man   = 24'h123456;
    bus.i_shamt = 8'd20;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", bus.o_busy, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.o_valid, 0);
    check("mid_rst_ready", bus.o_ready, 1);
    check("mid_rst_busy",  bus.o_busy,  0);
    check("mid_rst_man",   bus.o_man_ext, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nval = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.o_valid) nval++;
    end
    check("mid_rst_no_result", nval, 0);

    // Random operands against the one-shot reference.
    for (int i = 0; i < 10; i++) begin
      rm = 24'($urandom);
      rs = 8'($urandom_range(0, 40));
      do_op(rm, rs, ref_align(rm, int'(rs)), exp_lat(int'(rs)), 0, 1'b0,
            $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
